// File: rtl/systolic_pkg.sv
// systolic_pkg: state encoding, default sizes and index
// helpers shared by the systolic sequencer files.
package systolic_pkg;

   typedef enum logic [2:0] {
      LOAD,
      CLEAR,
      FEED,
      SETTLE,
      CAPTURE,
      OUT
   } state_e;

   function automatic int cnt_w(input int count);
      return $clog2(count) + 1;
   endfunction

   // Operand buffer holds A row-major, then B row-major.
   function automatic int buf_idx(
      input int n,
      input int row,
      input int col,
      input int mat
   );
      return mat * n * n + row * n + col;
   endfunction

   function automatic int skew_idx(input int t, input int lane);
      return t - lane;
   endfunction

   localparam int WIDTH_LP  = 8;
   localparam int N_LP      = 2;
   localparam int NN_LP     = N_LP * N_LP;
   localparam int LOAD_W_LP = cnt_w(2 * NN_LP);
   localparam int T_W_LP    = cnt_w(2 * N_LP - 1);

endpackage

// File: rtl/systolic_operand_buf.sv
// systolic_operand_buf: A/B operand register file with one
// write port and diagonally skewed row/column read ports.
module systolic_operand_buf
   import systolic_pkg::*;
#(
   parameter int width_p  = WIDTH_LP,
   parameter int n_p      = N_LP,
   parameter int addr_w_p = LOAD_W_LP,
   parameter int t_w_p    = T_W_LP
) (
   input  logic                   clk_i,
   input  logic                   reset_ni,
   input  logic                   we_i,
   input  logic [addr_w_p-1:0]    waddr_i,
   input  logic [width_p-1:0]     wdata_i,
   input  logic [t_w_p-1:0]       t_i,
   output logic [n_p*width_p-1:0] row_data_o,
   output logic [n_p-1:0]         row_hit_o,
   output logic [n_p*width_p-1:0] col_data_o,
   output logic [n_p-1:0]         col_hit_o
);

   localparam int DEPTH = 2 * n_p * n_p;
   localparam int IW    = $clog2(DEPTH);

   logic [width_p-1:0] mem_q [DEPTH];
   int                 k;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (waddr_i == addr_w_p'(i)) begin
               mem_q[i] <= wdata_i;
            end
         end
      end
   end

   // Lane l sees element t-l of its row of A / column of B.
   always_comb begin
      row_data_o = '0;
      row_hit_o  = '0;
      col_data_o = '0;
      col_hit_o  = '0;
      k          = 0;
      for (int l = 0; l < n_p; l++) begin
         k = skew_idx(int'(t_i), l);
         if (k >= 0 && k < n_p) begin
            row_hit_o[l] = 1'b1;
            col_hit_o[l] = 1'b1;
            row_data_o[l*width_p +: width_p] =
               mem_q[IW'(buf_idx(n_p, l, k, 0))];
            col_data_o[l*width_p +: width_p] =
               mem_q[IW'(buf_idx(n_p, k, l, 1))];
         end
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: loads A/B, feeds the PE grid with skew,
// waits for it to settle and streams the captured results.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int width_p         = WIDTH_LP,
   parameter int array_width_p   = N_LP,
   parameter int array_height_p  = N_LP,
   parameter int settle_cycles_p = 3
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 en_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [width_p-1:0]   data_i,
   output logic                 valid_o,
   input  logic                 yumi_i,
   output logic [width_p-1:0]   data_o,
   output logic [array_width_p*width_p-1:0] row_data_o,
   output logic [array_width_p-1:0]         row_valid_o,
   output logic [array_width_p*width_p-1:0] col_data_o,
   output logic [array_width_p-1:0]         col_valid_o,
   output logic                 acc_clear_o,
   output logic                 array_en_o,
   input  logic [array_width_p*array_width_p*width_p-1:0] acc_i,
   output logic                 busy_o
);

   localparam int N      = array_width_p;
   localparam int NN     = N * N;
   localparam int LOAD_W = cnt_w(2 * NN);
   localparam int OUT_W  = cnt_w(NN);
   localparam int T_W    = cnt_w(2 * N - 1);
   localparam int S_W    = cnt_w(settle_cycles_p);

   if (array_width_p != array_height_p) begin : g_bad_shape
      $error("systolic_seq_ctrl: PE array must be square");
   end
   if (settle_cycles_p < 1) begin : g_bad_settle
      $error("systolic_seq_ctrl: settle_cycles_p must be >= 1");
   end

   state_e             state_q;
   state_e             state_d;
   logic               live_q;
   logic [LOAD_W-1:0]  load_cnt_q;
   logic [T_W-1:0]     t_q;
   logic [S_W-1:0]     settle_q;
   logic [OUT_W-1:0]   out_cnt_q;
   logic [width_p-1:0] outbuf_q [NN];

   logic             hs_in;
   logic             hs_out;
   logic             load_last;
   logic             t_last;
   logic             settle_last;
   logic             out_last;
   logic             feed_en;
   logic [N*width_p-1:0] row_data;
   logic [N*width_p-1:0] col_data;
   logic [N-1:0]     row_hit;
   logic [N-1:0]     col_hit;

   assign hs_in       = ready_o & valid_i;
   assign hs_out      = valid_o & yumi_i;
   assign load_last   = load_cnt_q == LOAD_W'(2 * NN - 1);
   assign t_last      = t_q == T_W'(2 * N - 2);
   assign settle_last = settle_q == S_W'(settle_cycles_p - 1);
   assign out_last    = out_cnt_q == OUT_W'(NN - 1);

   systolic_operand_buf #(
      .width_p  (width_p),
      .n_p      (N),
      .addr_w_p (LOAD_W),
      .t_w_p    (T_W)
   ) u_buf (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .we_i       (hs_in & ~flush_i),
      .waddr_i    (load_cnt_q),
      .wdata_i    (data_i),
      .t_i        (t_q),
      .row_data_o (row_data),
      .row_hit_o  (row_hit),
      .col_data_o (col_data),
      .col_hit_o  (col_hit)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= LOAD;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = LOAD;
      end else if (en_i) begin
         unique case (state_q)
            LOAD:    if (hs_in && load_last) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (t_last) state_d = SETTLE;
            SETTLE:  if (settle_last) state_d = CAPTURE;
            CAPTURE: state_d = OUT;
            OUT:     if (hs_out && out_last) state_d = LOAD;
            default: state_d = LOAD;
         endcase
      end
   end

   always_comb begin
      ready_o     = 1'b0;
      valid_o     = 1'b0;
      acc_clear_o = 1'b0;
      array_en_o  = 1'b0;
      feed_en     = 1'b0;
      if (en_i) begin
         unique case (state_q)
            LOAD:    ready_o = live_q;
            CLEAR: begin
               acc_clear_o = 1'b1;
               array_en_o  = 1'b1;
            end
            FEED: begin
               array_en_o = 1'b1;
               feed_en    = 1'b1;
            end
            SETTLE:  array_en_o = 1'b1;
            CAPTURE: array_en_o = 1'b0;
            OUT:     valid_o = 1'b1;
            default: ready_o = 1'b0;
         endcase
      end
   end

   assign busy_o      = state_q != LOAD;
   assign row_valid_o = feed_en ? row_hit : '0;
   assign col_valid_o = feed_en ? col_hit : '0;
   assign row_data_o  = feed_en ? row_data : '0;
   assign col_data_o  = feed_en ? col_data : '0;

   // Flush outranks en_i so a frozen controller can still abort.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         load_cnt_q <= '0;
         t_q        <= '0;
         settle_q   <= '0;
         out_cnt_q  <= '0;
      end else if (flush_i) begin
         load_cnt_q <= '0;
         t_q        <= '0;
         settle_q   <= '0;
         out_cnt_q  <= '0;
      end else if (en_i) begin
         if (hs_in) begin
            load_cnt_q <= load_last ? '0
                        : load_cnt_q + LOAD_W'(1);
         end
         if (state_q == FEED) begin
            t_q <= t_last ? '0 : t_q + T_W'(1);
         end
         if (state_q == SETTLE) begin
            settle_q <= settle_last ? '0
                      : settle_q + S_W'(1);
         end
         if (hs_out) begin
            out_cnt_q <= out_last ? '0
                       : out_cnt_q + OUT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < NN; i++) begin
            outbuf_q[i] <= '0;
         end
      end else if (en_i && !flush_i && state_q == CAPTURE) begin
         for (int i = 0; i < NN; i++) begin
            outbuf_q[i] <= acc_i[i*width_p +: width_p];
         end
      end
   end

   always_comb begin
      data_o = '0;
      if (state_q == OUT) begin
         for (int i = 0; i < NN; i++) begin
            if (out_cnt_q == OUT_W'(i)) begin
               data_o = outbuf_q[i];
            end
         end
      end
   end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer in front of the N x N systolic multiply array.
- Collects operand matrices A and B over a ready/valid byte stream, then injects them into the array's row and column edges with diagonal skew.
- Waits for the array to settle, snapshots the accumulators, and streams the N*N results out over a valid/yumi port.
- Sits between the top-level stream interface and the PE grid.

Parameters:
- width_p, 8, element and accumulator width in bits.
- array_width_p, 2, number of PE columns (N); must equal array_height_p (elaboration assertion).
- array_height_p, 2, number of PE rows.
- settle_cycles_p, 3, idle cycles after the last injection before capture (PE pipeline depth across the grid).

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous, active-low reset.
- en_i  in  1  global enable; low freezes all state.
- flush_i  in  1  synchronous abort back to LOAD.
- valid_i  in  1  input element valid.
- ready_o  out  1  controller accepts an input element.
- data_i  in  width_p  input element.
- valid_o  out  1  result element valid.
- yumi_i  in  1  consumer takes data_o this cycle.
- data_o  out  width_p  result element.
- row_data_o  out  N*width_p  left-edge operands; row r at bits [r*width_p +: width_p].
- row_valid_o  out  N  per-row inject valid.
- col_data_o  out  N*width_p  top-edge operands; column c at bits [c*width_p +: width_p].
- col_valid_o  out  N  per-column inject valid.
- acc_clear_o  out  1  clear all PE accumulators.
- array_en_o  out  1  advance the PE grid.
- acc_i  in  N*N*width_p  PE accumulators, row-major; PE(r,c) at bits [(r*N+c)*width_p +: width_p].
- busy_o  out  1  high in any state other than LOAD.

Behaviour:
- Reset state (reset_ni low, asynchronous):
  - state = LOAD; all counters 0; all outputs 0.
  - ready_o rises the first enabled cycle after reset release.
- States: LOAD -> CLEAR -> FEED -> SETTLE -> CAPTURE -> OUT -> LOAD.
- LOAD:
  - ready_o = en_i.
  - Each valid_i & ready_o stores data_i at buffer index load_cnt.
  - Elements arrive as A row-major (indices 0..N*N-1), then B row-major (N*N..2*N*N-1).
  - On the 2*N*N-th handshake, go to CLEAR.
- CLEAR: one cycle; acc_clear_o = 1, array_en_o = 1. Next state FEED, t = 0.
- FEED: steps t = 0..2N-2, with array_en_o = 1.
  - Row r: row_valid_o[r] = 1 and data A[r][t-r] when 0 <= t-r < N; otherwise valid 0 and data 0.
  - Column c: col_valid_o[c] = 1 and data B[t-c][c] under the same rule.
  - After step 2N-2, go to SETTLE.
- SETTLE: array_en_o = 1 and all inject valids 0 for settle_cycles_p cycles, then CAPTURE.
- CAPTURE: one cycle; register acc_i into the output buffer; array_en_o = 0.
- OUT:
  - valid_o = en_i; data_o = outbuf[out_cnt].
  - yumi_i while valid_o advances out_cnt.
  - yumi_i while valid_o is low is ignored.
  - After the N*N-th yumi, go to LOAD with counters cleared.
  - data_o is held stable until yumi_i.
- Arithmetic: accumulation is modulo 2^width_p in the PEs; the controller performs no arithmetic on data.
- Fixed latency: with no stalls, last input handshake to first valid_o = 1 + (2N-1) + settle_cycles_p + 1 cycles.
- en_i low:
  - State, counters and buffers hold.
  - ready_o, valid_o, array_en_o, acc_clear_o and all inject valids are 0.
  - Handshakes are impossible.
- flush_i:
  - Highest synchronous priority, independent of en_i.
  - Next state LOAD; counters 0; a half-loaded operand set is discarded.
  - Outputs are as in LOAD on the following cycle; no acc_clear_o is issued.
  - A flush in the same cycle as a handshake: the handshake is dropped.
- Reset mid-operation: immediate return to the reset state; in-flight results are lost.
- Counter wrap:
  - load_cnt never exceeds 2*N*N-1 and out_cnt never exceeds N*N-1.
  - Counter widths are $clog2 of the count + 1.

Decomposition:
- Shared package systolic_pkg:
  - state enum (LOAD, CLEAR, FEED, SETTLE, CAPTURE, OUT).
  - Functions for operand-buffer index (row, col, matrix) and skew index t-r.
  - Localparams for N, N*N and the counter widths.
- One sub-module, systolic_operand_buf:
  - 2*N*N x width_p register file.
  - Single write port.
  - N+N combinational skewed read ports, driven by t.

Test Plan:
- Basic multiply: stream A = [1 2; 3 4], B = [1 2; 3 4] with the array model attached -> data_o sequence 7, 10, 15, 22, then ready_o high again.
- Skew check, same stimulus:
  - t0: row_valid_o = 01, rows {1, -}; col_valid_o = 01, cols {1, -}.
  - t1: row_valid_o = 11, rows {2, 3}; col_valid_o = 11, cols {3, 2}.
  - t2: row_valid_o = 10, rows {-, 4}; col_valid_o = 10, cols {-, 4}.
- Wrap and backpressure:
  - A = B = all 255 -> every result = 2.
  - Hold yumi_i low 5 cycles -> valid_o stays high and data_o stays stable.
- Stall: drop en_i for 3 cycles mid-FEED -> inject valids and array_en_o are 0; afterwards the t sequence resumes unchanged and results match the basic multiply.
- Flush: assert flush_i after 5 of 8 input elements -> next cycle ready_o = 1, busy_o = 0; a fresh full load yields correct results.
- Async reset: pull reset_ni low during OUT (between clock edges) -> valid_o, busy_o and array_en_o drop to 0 immediately; load_cnt restarts at 0.
